// File: rtl/mem_stage.sv
// Memory stage of the Y86-64 pipeline: one 8-byte load/store per cycle into a byte-addressed data memory, then the W register.
// Latency: m_valM/m_stat are combinational from the M inputs; W_* update one rising edge later.
// Backpressure: W_stall holds the W register only; the store of the instruction in M still commits.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset (W <- bubble)
//   M_stat/M_icode/M_cnd       status, instruction code, condition flag of the instruction in M
//   M_valE/M_valA              effective address / ALU result, store data / stack pointer
//   M_dstE/M_dstM              destination register IDs (4'hF = none)
//   W_stall                    hold the W register
//   m_valM, m_stat             combinational load data and post-check status (forwarding/control)
//   W_stat..W_dstM             W pipeline register outputs
module mem_stage #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic        M_cnd,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   output logic [63:0] m_valM,
   output logic [3:0]  m_stat,
   output logic [3:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam int AW = $clog2(MEM_BYTES);
   // Highest legal start address of an 8-byte access.
   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_AOK = 4'h1;
   localparam logic [3:0] S_ADR = 4'h3;

   localparam logic [3:0] R_NONE = 4'hF;

   // Byte-wide data memory; zero at time 0, untouched by reset.
   logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

   logic          rd_req;
   logic          wr_req;
   logic          use_valA_addr;
   logic [63:0]   mem_addr;
   logic          dmem_error;
   logic [AW-1:0] base;
   logic [63:0]   rd_data;
   logic          mem_we;

   // The condition flag only matters to pipeline control, not to this stage.
   logic unused_cnd;
   assign unused_cnd = M_cnd;

   always_comb begin
      rd_req        = 1'b0;
      wr_req        = 1'b0;
      use_valA_addr = 1'b0;
      case (M_icode)
         I_MRMOVQ: rd_req = 1'b1;
         I_RET: begin
            rd_req        = 1'b1;
            use_valA_addr = 1'b1;
         end
         I_POPQ: begin
            rd_req        = 1'b1;
            use_valA_addr = 1'b1;
         end
         I_RMMOVQ, I_CALL, I_PUSHQ: wr_req = 1'b1;
         default: begin
            rd_req = 1'b0;
            wr_req = 1'b0;
         end
      endcase
   end

   assign mem_addr = use_valA_addr ? M_valA : M_valE;

   // Full 64-bit unsigned compare: addresses near 2^64 must fault rather than
   // alias into the array through the truncated index below.
   assign dmem_error = (rd_req | wr_req) && (mem_addr > LAST_ADDR);

   // Only meaningful when dmem_error is low, which guarantees base+7 is in range.
   assign base = mem_addr[AW-1:0];

   // Little-endian, unaligned: byte addr+i supplies bits [8i+7:8i].
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 8; i++) begin
         rd_data[8*i +: 8] = mem[base + AW'(i)];
      end
   end

   assign m_valM = (rd_req && !dmem_error) ? rd_data : 64'h0;
   assign m_stat = dmem_error ? S_ADR : M_stat;

   // Faulting, non-AOK or reset-coincident stores leave memory untouched.
   assign mem_we = wr_req && !dmem_error && (M_stat == S_AOK) && !reset;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 8; i++) begin
            mem[base + AW'(i)] <= M_valA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         W_stat  <= S_AOK;
         W_icode <= I_NOP;
         W_valE  <= 64'h0;
         W_valM  <= 64'h0;
         W_dstE  <= R_NONE;
         W_dstM  <= R_NONE;
      end else if (!W_stall) begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

endmodule
